// File: rtl/cache_instructions.sv
// -----------------------------------------------------------------------------
// cache_instructions
//   Read-only, direct-mapped instruction cache between a CPU fetch stage and a
//   burst RAM. A hit answers from the stored line. A miss reads the whole line
//   with one burst and answers as soon as the beat holding the requested word
//   arrives (early restart). The cache keeps hit and miss counters that a bench
//   can read hierarchically.
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous reset, active high
//   enable            request strobe, taken only while busy = 0
//   address           word-aligned byte address of the instruction
//   data              fetched instruction, held until the next accepted request
//   data_ready        data is valid for the current request
//   busy              a request is in progress; new strobes are ignored
//   br_cmd            RAM command, always read (0)
//   br_cmd_en         one-cycle RAM command strobe
//   br_addr           burst start address, in burst words
//   br_rd_data        burst beat from the RAM
//   br_rd_data_valid  br_rd_data is valid this cycle
//   br_busy           RAM cannot take a command
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for a request, busy = 0
//   S_CHECK | compare the stored tag of the addressed line
//   S_REQ   | miss: wait for the RAM to go idle, then issue the burst read
//   S_FILL  | collect the burst beats into the line
// -----------------------------------------------------------------------------
module cache_instructions #(
    parameter int LINE_IX_BITWIDTH         = 1,
    parameter int ADDRESS_BITWIDTH         = 32,
    parameter int DATA_BITWIDTH            = 32,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_DEPTH_BITWIDTH       = 4,
    parameter int RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int RAM_BURST_DATA_COUNT     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [ADDRESS_BITWIDTH-1:0]        address,
    output logic [DATA_BITWIDTH-1:0]           data,
    output logic                               data_ready,
    output logic                               busy,
    output logic                               br_cmd,
    output logic                               br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
    input  logic                               br_rd_data_valid,
    input  logic                               br_busy
);

    localparam int NUM_LINES      = 1 << LINE_IX_BITWIDTH;
    localparam int WORDS_PER_LINE = 1 << DATA_IX_IN_LINE_BITWIDTH;
    localparam int WORDS_PER_BEAT = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int BYTE_OFF       = $clog2(DATA_BITWIDTH / 8);
    localparam int LINE_LO        = BYTE_OFF + DATA_IX_IN_LINE_BITWIDTH;
    localparam int TAG_LO         = LINE_LO + LINE_IX_BITWIDTH;
    localparam int TAG_W          = ADDRESS_BITWIDTH - TAG_LO;
    localparam int BURST_SHIFT    = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
    localparam int BEAT_W         = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam int SUB_W          = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RAM_BURST_DATA_COUNT - 1);
    // Bursts always start on a line boundary.
    localparam logic [RAM_DEPTH_BITWIDTH-1:0] BURST_ALIGN_MASK =
        ~RAM_DEPTH_BITWIDTH'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_FILL
    } state_t;

    state_t state_q, state_d;

    logic [ADDRESS_BITWIDTH-1:0]   addr_q, addr_d;
    logic [DATA_BITWIDTH-1:0]      data_q, data_d;
    logic                          data_ready_q, data_ready_d;
    logic                          busy_q, busy_d;
    logic                          br_cmd_en_q, br_cmd_en_d;
    logic [RAM_DEPTH_BITWIDTH-1:0] br_addr_q, br_addr_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic [NUM_LINES-1:0]          valid_q, valid_d;
    logic [TAG_W-1:0]              tag_q [NUM_LINES];
    logic [TAG_W-1:0]              tag_d [NUM_LINES];
    logic [DATA_BITWIDTH-1:0]      line_q [NUM_LINES][WORDS_PER_LINE];
    logic [DATA_BITWIDTH-1:0]      line_d [NUM_LINES][WORDS_PER_LINE];
    logic [31:0]                   stat_cache_hits_q, stat_cache_hits_d;
    logic [31:0]                   stat_cache_misses_q, stat_cache_misses_d;

    // Hierarchically visible statistics.
    logic [31:0] stat_cache_hits;
    logic [31:0] stat_cache_misses;
    assign stat_cache_hits   = stat_cache_hits_q;
    assign stat_cache_misses = stat_cache_misses_q;

    // Fields of the latched request.
    logic [DATA_IX_IN_LINE_BITWIDTH-1:0] req_word;
    logic [LINE_IX_BITWIDTH-1:0]         req_line;
    logic [TAG_W-1:0]                    req_tag;
    logic [BEAT_W-1:0]                   req_beat;
    logic [SUB_W-1:0]                    req_sub;
    logic [RAM_DEPTH_BITWIDTH-1:0]       fill_addr;
    logic                                hit;
    logic                                last_beat;
    logic                                unused_byte_offset;

    assign req_word  = addr_q[LINE_LO-1:BYTE_OFF];
    assign req_line  = addr_q[TAG_LO-1:LINE_LO];
    assign req_tag   = addr_q[ADDRESS_BITWIDTH-1:TAG_LO];
    assign req_beat  = BEAT_W'(32'(req_word) / WORDS_PER_BEAT);
    assign req_sub   = SUB_W'(32'(req_word) % WORDS_PER_BEAT);
    assign fill_addr = RAM_DEPTH_BITWIDTH'(addr_q >> BURST_SHIFT) & BURST_ALIGN_MASK;
    assign hit       = valid_q[req_line] && (tag_q[req_line] == req_tag);
    assign last_beat = (beat_q == LAST_BEAT);

    // Byte offset inside an instruction carries no information.
    assign unused_byte_offset = ^addr_q[BYTE_OFF-1:0];

    // Split one burst beat into instructions, lowest address in the low bits.
    logic [DATA_BITWIDTH-1:0] beat_words [WORDS_PER_BEAT];
    for (genvar g = 0; g < WORDS_PER_BEAT; g++) begin : g_beat_split
        assign beat_words[g] = br_rd_data[g*DATA_BITWIDTH +: DATA_BITWIDTH];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The fill ends on a beat count, never on a fixed latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_CHECK;
            S_CHECK: state_d = hit ? S_IDLE : S_REQ;
            S_REQ:   if (!br_busy) state_d = S_FILL;
            S_FILL:  if (br_rd_data_valid && last_beat) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath logic.
    logic [DATA_IX_IN_LINE_BITWIDTH-1:0] slot;

    always_comb begin
        addr_d              = addr_q;
        data_d              = data_q;
        data_ready_d        = data_ready_q;
        busy_d              = busy_q;
        br_cmd_en_d         = 1'b0;
        br_addr_d           = br_addr_q;
        beat_d              = beat_q;
        valid_d             = valid_q;
        tag_d               = tag_q;
        line_d              = line_q;
        stat_cache_hits_d   = stat_cache_hits_q;
        stat_cache_misses_d = stat_cache_misses_q;
        slot                = '0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    addr_d       = address;
                    data_ready_d = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            S_CHECK: begin
                if (hit) begin
                    data_d            = line_q[req_line][req_word];
                    data_ready_d      = 1'b1;
                    busy_d            = 1'b0;
                    stat_cache_hits_d = stat_cache_hits_q + 32'd1;
                end else begin
                    stat_cache_misses_d = stat_cache_misses_q + 32'd1;
                    // The line is being replaced; it must not look valid if the
                    // fill is abandoned.
                    valid_d[req_line] = 1'b0;
                end
            end
            S_REQ: begin
                if (!br_busy) begin
                    br_cmd_en_d = 1'b1;
                    br_addr_d   = fill_addr;
                    beat_d      = '0;
                end
            end
            S_FILL: begin
                if (br_rd_data_valid) begin
                    for (int j = 0; j < WORDS_PER_BEAT; j++) begin
                        slot = DATA_IX_IN_LINE_BITWIDTH'(32'(beat_q) * WORDS_PER_BEAT + j);
                        line_d[req_line][slot] = beat_words[j];
                    end
                    // Early restart: answer as soon as the wanted word shows up.
                    if (beat_q == req_beat) begin
                        data_d       = beat_words[req_sub];
                        data_ready_d = 1'b1;
                    end
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        tag_d[req_line]   = req_tag;
                        valid_d[req_line] = 1'b1;
                        busy_d            = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q              <= '0;
            data_q              <= '0;
            data_ready_q        <= 1'b0;
            busy_q              <= 1'b0;
            br_cmd_en_q         <= 1'b0;
            br_addr_q           <= '0;
            beat_q              <= '0;
            valid_q             <= '0;
            tag_q               <= '{default: '0};
            line_q              <= '{default: '{default: '0}};
            stat_cache_hits_q   <= '0;
            stat_cache_misses_q <= '0;
        end else begin
            addr_q              <= addr_d;
            data_q              <= data_d;
            data_ready_q        <= data_ready_d;
            busy_q              <= busy_d;
            br_cmd_en_q         <= br_cmd_en_d;
            br_addr_q           <= br_addr_d;
            beat_q              <= beat_d;
            valid_q             <= valid_d;
            tag_q               <= tag_d;
            line_q              <= line_d;
            stat_cache_hits_q   <= stat_cache_hits_d;
            stat_cache_misses_q <= stat_cache_misses_d;
        end
    end

    assign data       = data_q;
    assign data_ready = data_ready_q;
    assign busy       = busy_q;
    assign br_cmd     = 1'b0;
    assign br_cmd_en  = br_cmd_en_q;
    assign br_addr    = br_addr_q;

endmodule

// File: tb/tb_cache_instructions.sv
module tb_cache_instructions;

    localparam int RAM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        data_ready;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;

    always #5 clk = ~clk;

    cache_instructions dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .address          (address),
        .data             (data),
        .data_ready       (data_ready),
        .busy             (busy),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    // ---------------- burst RAM model ----------------
    logic [63:0] mem [16];
    logic [1:0]  ram_state = 2'd0;
    int          ram_lat   = 0;
    logic [3:0]  ram_addr  = '0;
    logic [1:0]  ram_beat  = '0;

    initial begin
        br_busy          = 1'b0;
        br_rd_data_valid = 1'b0;
        br_rd_data       = '0;
    end

    always @(posedge clk) begin
        br_rd_data_valid <= 1'b0;
        case (ram_state)
            2'd0: begin
                if (br_cmd_en) begin
                    br_busy   <= 1'b1;
                    ram_lat   <= RAM_LAT;
                    ram_addr  <= br_addr;
                    ram_beat  <= 2'd0;
                    ram_state <= 2'd1;
                end
            end
            2'd1: begin
                if (ram_lat == 1) ram_state <= 2'd2;
                ram_lat <= ram_lat - 1;
            end
            default: begin
                br_rd_data_valid <= 1'b1;
                br_rd_data       <= mem[ram_addr + 4'(ram_beat)];
                ram_beat         <= ram_beat + 2'd1;
                if (ram_beat == 2'd3) begin
                    ram_state <= 2'd0;
                    br_busy   <= 1'b0;
                end
            end
        endcase
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [63:0] w;
        w = mem[a[6:3]];
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    // ---------------- reference cache model and scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        sb[$];
    logic        m_valid [2];
    logic [25:0] m_tag   [2];
    int          exp_hits   = 0;
    int          exp_misses = 0;
    int          n_cmd      = 0;
    logic [3:0]  last_br_addr = '0;
    logic        dr_prev = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (br_cmd_en) begin
                n_cmd++;
                last_br_addr = br_addr;
            end
            if (data_ready && !dr_prev) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 64'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    chk("data", data, e.data);
                    chk("busy_at_ready", busy, e.busy);
                end
            end
            dr_prev = data_ready;
        end
    end

    function automatic void model_reset();
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_tag[0]   = '0;
        m_tag[1]   = '0;
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    // One fetch; called at a negedge with the cache idle.
    task automatic do_read(input logic [31:0] addr, input bit noise);
        exp_t e;
        bit   hit;
        int   cmd0;
        int   cyc;
        bit   done;
        hit = m_valid[addr[5]] && (m_tag[addr[5]] == addr[31:6]);
        e.data = ref_word(addr);
        e.busy = hit ? 1'b0 : (addr[4:3] != 2'b11);
        sb.push_back(e);
        if (hit) exp_hits++;
        else begin
            exp_misses++;
            m_valid[addr[5]] = 1'b1;
            m_tag[addr[5]]   = addr[31:6];
        end
        cmd0    = n_cmd;
        address = addr;
        enable  = 1'b1;
        @(negedge clk);
        enable  = 1'b0;
        address = 32'hFFFF_FFFC;
        chk("accept_busy", busy, 1);
        chk("accept_ready_low", data_ready, 0);
        cyc = 0;
        while (!(!busy && data_ready) && cyc < 200) begin
            if (noise && cyc == 2) begin
                enable  = 1'b1;
                address = 32'h0000_0050;
            end else begin
                enable = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        enable = 1'b0;
        done = !busy && data_ready;
        chk("done", done, 1);
        if (hit) chk("hit_latency", 64'(cyc), 1);
        chk("cmd_pulses", 64'(n_cmd - cmd0), hit ? 1'b0 : 1'b1);
        if (!hit) chk("br_addr", last_br_addr, {addr[6:5], 2'b00});
        chk("hits", dut.stat_cache_hits, 64'(exp_hits));
        chk("misses", dut.stat_cache_misses, 64'(exp_misses));
        repeat (3) @(negedge clk);
        chk("hold_data", data, ref_word(addr));
        chk("hold_ready", data_ready, 1);
        chk("sb_drained", 64'(sb.size()), 0);
    endtask

    // Reset in the middle of a burst fill.
    task automatic rst_during_fill(input logic [31:0] addr);
        int beats;
        int cyc;
        address = addr;
        enable  = 1'b1;
        @(negedge clk);
        enable  = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (br_rd_data_valid) beats++;
        end
        chk("fill_started", 64'(beats), 2);
        rst = 1'b1;
        #1;
        chk("rst_data", data, 0);
        chk("rst_ready", data_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_en", br_cmd_en, 0);
        chk("rst_hits", dut.stat_cache_hits, 0);
        chk("rst_misses", dut.stat_cache_misses, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = {32'hC000_0000 + 32'(i * 8 + 4), 32'hC000_0000 + 32'(i * 8)};
        end
        mem[0][31:0]  = 32'hB7C6_A980;
        mem[0][63:32] = 32'h3F5A_2E14;
        mem[1][31:0]  = 32'hAB4C_3E6F;
        mem[2][31:0]  = 32'hD5B8_A9C4;
        mem[4][31:0]  = 32'h2F5E_3C7A;
        mem[8][63:32] = 32'h0A1B_2C3D;

        model_reset();
        rst     = 1'b1;
        enable  = 1'b0;
        address = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", data, 0);
        chk("reset_ready", data_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cmd_en", br_cmd_en, 0);
        chk("reset_cmd", br_cmd, 0);
        chk("reset_hits", dut.stat_cache_hits, 0);
        chk("reset_misses", dut.stat_cache_misses, 0);

        do_read(32'd0,  1'b0);
        do_read(32'd4,  1'b0);
        do_read(32'd8,  1'b0);
        do_read(32'd16, 1'b0);
        do_read(32'd32, 1'b1);
        do_read(32'd68, 1'b0);
        do_read(32'd0,  1'b0);
        do_read(32'd36, 1'b0);
        do_read(32'd28, 1'b0);

        rst_during_fill(32'd120);
        do_read(32'd120, 1'b0);
        do_read(32'd124, 1'b0);
        do_read(32'd0,   1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
